// File: rtl/radix_4_otf_converter_pkg.sv
// Shared definitions for the radix-4 divider quotient path: one-hot digit
// bit positions and the converter FSM states.
package radix_4_pkg;

    localparam int QUO_NEG_2 = 0;
    localparam int QUO_NEG_1 = 1;
    localparam int QUO_ZERO  = 2;
    localparam int QUO_POS_1 = 3;
    localparam int QUO_POS_2 = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } conv_state_e;

endpackage

// File: rtl/radix_4_otf_converter_if.sv
// Start / digit / result handshake bundle of the on-the-fly quotient converter.
// The slave side is the converter; the master side is whoever feeds it digits.
interface radix_4_otf_converter_if #(
    parameter int QUO_W  = 64,
    parameter int ITER_W = $clog2(QUO_W/2+1)
);
    logic              start_i;
    logic [ITER_W-1:0] iter_num_i;
    logic              start_rdy_o;
    logic              quo_dig_vld_i;
    logic [4:0]        quo_dig_i;
    logic              rem_neg_i;
    logic              quo_vld_o;
    logic              quo_rdy_i;
    logic [QUO_W-1:0]  quo_o;
    logic              err_o;

    modport master (
        output start_i, iter_num_i, quo_dig_vld_i, quo_dig_i, rem_neg_i, quo_rdy_i,
        input  start_rdy_o, quo_vld_o, quo_o, err_o
    );

    modport slave (
        input  start_i, iter_num_i, quo_dig_vld_i, quo_dig_i, rem_neg_i, quo_rdy_i,
        output start_rdy_o, quo_vld_o, quo_o, err_o
    );

endinterface

// File: rtl/radix_4_otf_converter_step.sv
// One combinational on-the-fly conversion step: folds a one-hot radix-4 digit
// into the (Q, QM = Q-1) pair without a carry-propagate adder.
module radix_4_otf_step
    import radix_4_pkg::*;
#(
    parameter int QUO_W = 64
) (
    input  logic [QUO_W-1:0] q,
    input  logic [QUO_W-1:0] qm,
    input  logic [4:0]       dig,
    output logic [QUO_W-1:0] q_nxt,
    output logic [QUO_W-1:0] qm_nxt,
    output logic             dig_err
);

    // Anything that is not exactly one-hot falls into the zero-digit update.
    always_comb begin
        q_nxt   = {q[QUO_W-3:0], 2'd0};
        qm_nxt  = {qm[QUO_W-3:0], 2'd3};
        dig_err = 1'b0;
        case (dig)
            (5'd1 << QUO_POS_2): begin
                q_nxt  = {q[QUO_W-3:0], 2'd2};
                qm_nxt = {q[QUO_W-3:0], 2'd1};
            end
            (5'd1 << QUO_POS_1): begin
                q_nxt  = {q[QUO_W-3:0], 2'd1};
                qm_nxt = {q[QUO_W-3:0], 2'd0};
            end
            (5'd1 << QUO_ZERO): begin
                q_nxt  = {q[QUO_W-3:0], 2'd0};
                qm_nxt = {qm[QUO_W-3:0], 2'd3};
            end
            (5'd1 << QUO_NEG_1): begin
                q_nxt  = {qm[QUO_W-3:0], 2'd3};
                qm_nxt = {qm[QUO_W-3:0], 2'd2};
            end
            (5'd1 << QUO_NEG_2): begin
                q_nxt  = {qm[QUO_W-3:0], 2'd2};
                qm_nxt = {qm[QUO_W-3:0], 2'd1};
            end
            default: dig_err = 1'b1;
        endcase
    end

endmodule

// File: rtl/radix_4_otf_converter.sv
// On-the-fly radix-4 quotient converter: accumulates one digit per accepted
// cycle, applies the remainder-sign correction and holds the result for handoff.
module radix_4_otf_converter
    import radix_4_pkg::*;
#(
    parameter int QUO_W  = 64,
    parameter int ITER_W = $clog2(QUO_W/2+1)
) (
    input logic                     clk,
    input logic                     rst,
    radix_4_otf_converter_if.slave  bus
);

    conv_state_e       state;
    conv_state_e       state_nxt;
    logic [QUO_W-1:0]  q;
    logic [QUO_W-1:0]  qm;
    logic [QUO_W-1:0]  q_step;
    logic [QUO_W-1:0]  qm_step;
    logic [QUO_W-1:0]  quo;
    logic [ITER_W-1:0] cnt;
    logic              err;
    logic              dig_err;
    logic              start_acc;
    logic              dig_acc;

    assign start_acc = (state == IDLE) && bus.start_i;
    assign dig_acc   = (state == CONV) && bus.quo_dig_vld_i;

    radix_4_otf_step #(.QUO_W(QUO_W)) u_step (
        .q       (q),
        .qm      (qm),
        .dig     (bus.quo_dig_i),
        .q_nxt   (q_step),
        .qm_nxt  (qm_step),
        .dig_err (dig_err)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (bus.start_i)
                      state_nxt = (bus.iter_num_i == '0) ? FIX : CONV;
            CONV: if (bus.quo_dig_vld_i && (cnt == ITER_W'(1)))
                      state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (bus.quo_rdy_i)
                      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // QM starts at all-ones so that a leading negative digit borrows correctly.
    always_ff @(posedge clk) begin
        if (rst) begin
            q   <= '0;
            qm  <= '0;
            cnt <= '0;
            err <= 1'b0;
            quo <= '0;
        end else begin
            if (start_acc) begin
                q   <= '0;
                qm  <= '1;
                cnt <= bus.iter_num_i;
                err <= 1'b0;
            end else if (dig_acc) begin
                q   <= q_step;
                qm  <= qm_step;
                cnt <= cnt - ITER_W'(1);
                if (dig_err)
                    err <= 1'b1;
            end
            if (state == FIX)
                quo <= bus.rem_neg_i ? qm : q;
        end
    end

    always_comb begin
        bus.start_rdy_o = (state == IDLE);
        bus.quo_vld_o   = (state == DONE);
        bus.quo_o       = quo;
        bus.err_o       = err;
    end

endmodule

// File: tb/tb_radix_4_otf_converter.sv
// Bench for radix_4_otf_converter: directed vector table, randomized runs
// against an arithmetic quotient model, backpressure and mid-conversion reset.
module tb_radix_4_otf_converter;

    localparam int W  = 4;
    localparam int IW = $clog2(W/2+1);

    localparam logic [4:0] D_N2 = 5'b00001;
    localparam logic [4:0] D_N1 = 5'b00010;
    localparam logic [4:0] D_Z  = 5'b00100;
    localparam logic [4:0] D_P1 = 5'b01000;
    localparam logic [4:0] D_P2 = 5'b10000;

    typedef logic [4:0] dig_arr_t [4];

    typedef struct {
        int           n;
        dig_arr_t     digs;
        int           stalls;
        bit           rem_neg;
        int           hold;
        logic [W-1:0] exp_q;
        bit           exp_err;
        int           exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;

    always #5 clk = ~clk;

    radix_4_otf_converter_if #(.QUO_W(W)) bus ();

    radix_4_otf_converter #(.QUO_W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic int digVal(input logic [4:0] d);
        case (d)
            D_N2:    return -2;
            D_N1:    return -1;
            D_P1:    return 1;
            D_P2:    return 2;
            default: return 0;
        endcase
    endfunction

    // The quotient is simply the digit string read as a base-4 number, minus
    // one when the final remainder is negative, reduced mod 2^W.
    function automatic logic [W-1:0] modelQuo(input int n, input dig_arr_t digs, input bit rem_neg);
        longint v = 0;
        for (int i = 0; i < n; i++) v = v * 4 + longint'(digVal(digs[i]));
        if (rem_neg) v = v - 1;
        return W'(v);
    endfunction

    task automatic applyStimulus(input string tag, input int n, input dig_arr_t digs,
                                 input int stalls, input bit rem_neg, input int hold,
                                 input logic [W-1:0] exp_q, input bit exp_err, input int exp_lat);
        int lat;
        int k;
        bus.rem_neg_i  = rem_neg;
        bus.iter_num_i = IW'(n);
        bus.start_i    = 1'b1;
        tick();
        bus.start_i = 1'b0;
        lat = 1;
        checkOutput({tag, " start_rdy_busy"}, bus.start_rdy_o, 0);
        checkOutput({tag, " err_cleared"}, bus.err_o, 0);
        for (int i = 0; i < n; i++) begin
            if (i > 0) begin
                for (int s = 0; s < stalls; s++) begin
                    bus.quo_dig_vld_i = 1'b0;
                    bus.quo_dig_i     = D_P2;
                    tick();
                    lat++;
                end
            end
            bus.quo_dig_vld_i = 1'b1;
            bus.quo_dig_i     = digs[i];
            tick();
            lat++;
        end
        bus.quo_dig_vld_i = 1'b0;
        bus.quo_dig_i     = 5'b11111;
        k = 0;
        while (!bus.quo_vld_o && k < 30) begin
            tick();
            lat++;
            k++;
        end
        checkOutput({tag, " vld_seen"}, bus.quo_vld_o, 1);
        checkOutput({tag, " latency"}, lat, exp_lat);
        checkOutput({tag, " quo"}, bus.quo_o, exp_q);
        checkOutput({tag, " err"}, bus.err_o, exp_err);
        for (int h = 0; h < hold; h++) begin
            bus.start_i       = 1'b1;
            bus.quo_dig_vld_i = 1'b1;
            bus.rem_neg_i     = ~rem_neg;
            tick();
            checkOutput({tag, " hold_vld"}, bus.quo_vld_o, 1);
            checkOutput({tag, " hold_quo"}, bus.quo_o, exp_q);
            checkOutput({tag, " hold_start_rdy"}, bus.start_rdy_o, 0);
        end
        bus.start_i       = 1'b0;
        bus.quo_dig_vld_i = 1'b0;
        bus.quo_rdy_i     = 1'b1;
        tick();
        bus.quo_rdy_i = 1'b0;
        checkOutput({tag, " vld_drop"}, bus.quo_vld_o, 0);
        checkOutput({tag, " start_rdy_back"}, bus.start_rdy_o, 1);
    endtask

    initial begin
        vec_t     vecs [10];
        dig_arr_t rd;
        int       rn;
        int       rs;
        bit       rneg;
        bit       rerr;

        vecs[0] = '{2, '{D_P2, D_P1, D_Z, D_Z}, 0, 1'b0, 0, 4'd9,  1'b0, 4};
        vecs[1] = '{2, '{D_P1, D_N1, D_Z, D_Z}, 0, 1'b0, 0, 4'd3,  1'b0, 4};
        vecs[2] = '{2, '{D_P1, D_N1, D_Z, D_Z}, 0, 1'b1, 0, 4'd2,  1'b0, 4};
        vecs[3] = '{2, '{D_Z,  D_N2, D_Z, D_Z}, 0, 1'b0, 0, 4'd14, 1'b0, 4};
        vecs[4] = '{2, '{D_Z,  D_N2, D_Z, D_Z}, 3, 1'b0, 0, 4'd14, 1'b0, 7};
        vecs[5] = '{2, '{5'b00110, D_P1, D_Z, D_Z}, 0, 1'b0, 0, 4'd1, 1'b1, 4};
        vecs[6] = '{0, '{D_Z,  D_Z,  D_Z, D_Z}, 0, 1'b0, 0, 4'd0,  1'b0, 2};
        vecs[7] = '{0, '{D_Z,  D_Z,  D_Z, D_Z}, 0, 1'b1, 0, 4'd15, 1'b0, 2};
        vecs[8] = '{2, '{D_N2, D_N2, D_Z, D_Z}, 1, 1'b1, 0, 4'd5,  1'b0, 5};
        vecs[9] = '{2, '{D_P2, D_P1, D_Z, D_Z}, 0, 1'b0, 5, 4'd9,  1'b0, 4};

        rst               = 1'b1;
        bus.start_i       = 1'b0;
        bus.iter_num_i    = '0;
        bus.quo_dig_vld_i = 1'b0;
        bus.quo_dig_i     = D_Z;
        bus.rem_neg_i     = 1'b0;
        bus.quo_rdy_i     = 1'b0;
        tick();
        tick();
        checkOutput("reset quo", bus.quo_o, 0);
        checkOutput("reset vld", bus.quo_vld_o, 0);
        checkOutput("reset err", bus.err_o, 0);
        checkOutput("reset start_rdy", bus.start_rdy_o, 1);
        rst = 1'b0;
        tick();

        for (int v = 0; v < 10; v++)
            applyStimulus($sformatf("vec%0d", v), vecs[v].n, vecs[v].digs, vecs[v].stalls,
                          vecs[v].rem_neg, vecs[v].hold, vecs[v].exp_q, vecs[v].exp_err,
                          vecs[v].exp_lat);

        for (int r = 0; r < 40; r++) begin
            rn   = int'($urandom_range(0, 2));
            rs   = int'($urandom_range(0, 2));
            rneg = 1'($urandom_range(0, 1));
            rerr = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 9) < 8) rd[i] = 5'd1 << $urandom_range(0, 4);
                else                          rd[i] = 5'($urandom);
                if (i < rn && !$onehot(rd[i])) rerr = 1'b1;
            end
            applyStimulus($sformatf("rand%0d", r), rn, rd, rs, rneg, int'($urandom_range(0, 1)),
                          modelQuo(rn, rd, rneg), rerr, rn + 2 + ((rn > 1) ? rs * (rn - 1) : 0));
        end

        applyStimulus("pre_reset", 2, vecs[0].digs, 0, 1'b0, 0, 4'd9, 1'b0, 4);
        bus.iter_num_i = IW'(2);
        bus.start_i    = 1'b1;
        tick();
        bus.start_i       = 1'b0;
        bus.quo_dig_vld_i = 1'b1;
        bus.quo_dig_i     = 5'b00110;
        tick();
        checkOutput("mid_conv err", bus.err_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.quo_dig_vld_i = 1'b0;
        checkOutput("abort quo", bus.quo_o, 0);
        checkOutput("abort vld", bus.quo_vld_o, 0);
        checkOutput("abort err", bus.err_o, 0);
        checkOutput("abort start_rdy", bus.start_rdy_o, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("abort no_vld", bus.quo_vld_o, 0);
        end
        applyStimulus("post_reset", 2, vecs[1].digs, 0, 1'b0, 0, 4'd3, 1'b0, 4);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/radix_4_otf_converter.md
# radix_4_otf_converter

On-the-fly quotient converter for the radix-4 integer divider datapath. It consumes one radix-4 quotient digit per cycle in one-hot form (−2..+2) and keeps two running quotients, Q and QM = Q − 1 ulp, so no carry-propagate adder is needed. After the last digit it applies the final-remainder sign correction and presents the non-redundant quotient behind a valid/ready handshake. It sits between the per-iteration digit-selection logic and the divider's result formatting stage.

## Interface
- `QUO_W`, default 64: quotient width in bits; must be even and ≥ 4.
- `ITER_W`, default `$clog2(QUO_W/2+1)`: iteration counter width; derived, not overridden.
- `clk` input 1: the single clock.
- `rst` input 1: reset; **one clock; reset is synchronous and active-high**.
- `start_i` input 1: request a new conversion; accepted only when `start_rdy_o` = 1.
- `iter_num_i` input ITER_W: number of digits to consume, 0..QUO_W/2; sampled on start.
- `start_rdy_o` output 1: high only in IDLE.
- `quo_dig_vld_i` input 1: `quo_dig_i` is valid this cycle.
- `quo_dig_i` input 5: one-hot digit. bit0 = −2, bit1 = −1, bit2 = 0, bit3 = +1, bit4 = +2.
- `rem_neg_i` input 1: sign of the final remainder; sampled in FIX.
- `quo_vld_o` output 1: result valid.
- `quo_rdy_i` input 1: consumer accepts the result.
- `quo_o` output QUO_W: final quotient.
- `err_o` output 1: sticky flag, set when a non-one-hot digit is accepted.

## Operation
- FSM states: IDLE, CONV, FIX, DONE.
- **IDLE**
  - On `start_i`: Q ← 0, QM ← all-ones, cnt ← `iter_num_i`, `err_o` ← 0.
  - Next state is CONV, or FIX if `iter_num_i` = 0.
- **CONV**
  - A digit is accepted in any cycle with `quo_dig_vld_i` = 1.
  - Cycles with `quo_dig_vld_i` = 0 are stalls: Q, QM and cnt hold.
- **Update rule per accepted digit d** (shift-left by 2, then OR in the low bits):
  - d = +2: Q = Q<<2 | 2, QM = Q<<2 | 1.
  - d = +1: Q = Q<<2 | 1, QM = Q<<2 | 0.
  - d = 0: Q = Q<<2 | 0, QM = QM<<2 | 3.
  - d = −1: Q = QM<<2 | 3, QM = QM<<2 | 2.
  - d = −2: Q = QM<<2 | 2, QM = QM<<2 | 1.
  - Bits shifted out of the top are discarded (mod 2^QUO_W).
- **Digit errors**
  - A digit that is not one-hot (zero bits or several bits set) is treated as d = 0 and sets `err_o`.
  - `err_o` stays set until the next accepted start or reset.
- **Counting**
  - cnt decrements on each accepted digit.
  - When the digit that takes cnt from 1 to 0 is accepted, the next state is FIX.
- **FIX** (exactly one cycle)
  - Output register ← QM if `rem_neg_i` = 1, else Q.
  - Next state is DONE.
- **DONE**
  - `quo_vld_o` = 1 and `quo_o` is stable until `quo_rdy_i` = 1.
  - On `quo_rdy_i` = 1, next state is IDLE.
- **Ignored inputs**
  - `start_i` outside IDLE.
  - `quo_dig_vld_i` outside CONV.
  - `quo_rdy_i` outside DONE.

## Timing
- Reset values: state IDLE, Q = 0, QM = 0, cnt = 0, `quo_o` = 0, `quo_vld_o` = 0, `err_o` = 0, `start_rdy_o` = 1.
- Reset in any state aborts the conversion at the next edge with no result produced.
- Start accepted in cycle T: the first digit can be accepted in cycle T+1.
- N digits with no stalls: FIX in cycle T+N+1, `quo_vld_o` high from cycle T+N+2.
- `iter_num_i` = 0: FIX in T+1, DONE in T+2. The result is 0, or all-ones if `rem_neg_i` = 1.
- Handshake completes in a cycle with `quo_vld_o` & `quo_rdy_i`:
  - `quo_vld_o` is low the next cycle and `start_rdy_o` is high.
  - Minimum restart spacing: one IDLE cycle.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `radix_4_pkg`:
  - digit one-hot bit indices `QUO_NEG_2`=0, `QUO_NEG_1`=1, `QUO_ZERO`=2, `QUO_POS_1`=3, `QUO_POS_2`=4;
  - the FSM state enum.
- Sub-module `radix_4_otf_step`: purely combinational. Takes (Q, QM, digit) and produces (next Q, next QM, digit-invalid flag). It can be reused later for an unrolled 2-digit-per-cycle radix-16 variant.

## Test plan
- QUO_W = 4, N = 2, digits +2, +1, `rem_neg_i` = 0 → `quo_o` = 4'b1001 (9). `quo_vld_o` rises 4 cycles after start.
- QUO_W = 4, N = 2, digits +1, −1:
  - `rem_neg_i` = 0 → `quo_o` = 3;
  - same sequence with `rem_neg_i` = 1 → `quo_o` = 2.
- QUO_W = 4, N = 2, digits 0, −2 → `quo_o` = 4'b1110 (−2 mod 16). Also insert 3 stall cycles between the digits and check that Q/QM hold and latency extends by 3.
- Digit 5'b00110 accepted → treated as zero and `err_o` = 1; `err_o` clears on the next start.
- Backpressure: hold `quo_rdy_i` = 0 for 5 cycles → `quo_o` stable and `start_i` ignored; release → IDLE next cycle.
- Reset in CONV after one digit → all outputs reach their reset values after one edge, and no `quo_vld_o` pulse occurs.
